// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises raw sources, latches edge/level pending flags
// and presents a fixed-priority request/acknowledge handshake to the CPU.
module irq_ctrl #(
    parameter int                N_CH        = 4,
    parameter int                CAUSE_W     = 2,
    parameter logic [N_CH-1:0]   EDGE_MASK   = '1,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      irq_i,
    input  logic [N_CH-1:0]      mask_i,
    input  logic                 ack,
    output logic                 int_req,
    output logic [CAUSE_W-1:0]   int_cause,
    output logic [N_CH-1:0]      pending
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                         state;
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                sync_last;
    logic [N_CH-1:0]                sync_dly;
    logic [N_CH-1:0]                rose;
    logic [N_CH-1:0]                clr;
    logic [N_CH-1:0]                req_vec;
    logic [N_CH-1:0]                pending_nxt;
    logic [CAUSE_W-1:0]             winner;

    // NOTE: clocked state is always assigned with <=, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= irq_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign rose      = sync_last & ~sync_dly;
    assign req_vec   = pending & mask_i;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_CH; i++) begin
            clr[i] = (state == REQ) && ack && EDGE_MASK[i] && (int_cause == CAUSE_W'(i));
        end
    end

    // A new edge overrides a same-cycle acknowledge so it is never lost.
    assign pending_nxt = (EDGE_MASK & (rose | (pending & ~clr))) | (~EDGE_MASK & sync_last);

    // Scanning downward leaves the lowest-index requester as the winner.
    always_comb begin
        winner = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            int_req   <= 1'b0;
            int_cause <= '0;
            sync_dly  <= '0;
            pending   <= '0;
        end else begin
            sync_dly <= sync_last;
            pending  <= pending_nxt;
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        int_cause <= winner;
                        int_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        int_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
